// File: rtl/sr_flipflop_driver.sv
// sr_flipflop_driver: command-side driver for a bank of WIDTH gated SR flops.
// A requested Q vector is turned into non-overlapping S/R pulses. After a
// settle window, the Q feedback is compared against the request.
// Optional build macro SR_DRV_RETRY_EN: a failed check re-drives the bank up to
// MAX_RETRY more times before reporting done with err.
module sr_flipflop_driver #(
    parameter int WIDTH         = 8,
    parameter int PULSE_CYCLES  = 1,
    parameter int SETTLE_CYCLES = 2,
    parameter int MAX_RETRY     = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_data,
    input  logic [WIDTH-1:0] Q_fb,
    output logic [WIDTH-1:0] S,
    output logic [WIDTH-1:0] R,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] err_bits
);

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // One counter width serves the pulse, settle and retry counts.
    localparam int CNT_MAX = max3(PULSE_CYCLES, SETTLE_CYCLES, MAX_RETRY);
    localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

    // Set only bits that must rise and clear only bits that must fall.
    // The two masks are disjoint, so S and R are never both high on a bit.
    function automatic logic [WIDTH-1:0] set_mask(input logic [WIDTH-1:0] tgt_v,
                                                  input logic [WIDTH-1:0] cur_v);
        return tgt_v & ~cur_v;
    endfunction

    function automatic logic [WIDTH-1:0] clr_mask(input logic [WIDTH-1:0] tgt_v,
                                                  input logic [WIDTH-1:0] cur_v);
        return ~tgt_v & cur_v;
    endfunction

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SETTLE = 2'd2,
        CHECK  = 2'd3
    } state_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   tgt, tgt_nxt;
    logic [WIDTH-1:0]   snap, snap_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [WIDTH-1:0]   s_nxt, r_nxt, err_bits_nxt;
    logic               done_nxt, err_nxt, ready_nxt;
    logic [WIDTH-1:0]   mism;
`ifdef SR_DRV_RETRY_EN
    logic [CNT_W-1:0]   retry_cnt, retry_nxt;
`endif

    assign mism = Q_fb ^ tgt;

    // Next-state and next-output logic; every output is registered below,
    // so S/R/done/req_ready change together with the state.
    always_comb begin
        state_nxt    = state;
        tgt_nxt      = tgt;
        snap_nxt     = snap;
        cnt_nxt      = cnt;
        s_nxt        = '0;
        r_nxt        = '0;
        done_nxt     = 1'b0;
        err_nxt      = 1'b0;
        err_bits_nxt = err_bits;
        ready_nxt    = 1'b0;
`ifdef SR_DRV_RETRY_EN
        retry_nxt    = retry_cnt;
`endif
        unique case (state)
            IDLE: begin
                ready_nxt = 1'b1;
                if (req_valid && req_ready) begin
                    tgt_nxt   = req_data;
                    snap_nxt  = Q_fb;
                    cnt_nxt   = '0;
                    state_nxt = DRIVE;
                    ready_nxt = 1'b0;
                    s_nxt     = set_mask(req_data, Q_fb);
                    r_nxt     = clr_mask(req_data, Q_fb);
`ifdef SR_DRV_RETRY_EN
                    retry_nxt = '0;
`endif
                end
            end
            DRIVE: begin
                if (cnt == CNT_W'(PULSE_CYCLES - 1)) begin
                    cnt_nxt   = '0;
                    state_nxt = (SETTLE_CYCLES == 0) ? CHECK : SETTLE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                    s_nxt   = set_mask(tgt, snap);
                    r_nxt   = clr_mask(tgt, snap);
                end
            end
            SETTLE: begin
                if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                    cnt_nxt   = '0;
                    state_nxt = CHECK;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            CHECK: begin
                err_bits_nxt = mism;
`ifdef SR_DRV_RETRY_EN
                if ((|mism) && (retry_cnt < CNT_W'(MAX_RETRY))) begin
                    // Re-drive from whatever the bank actually holds now.
                    retry_nxt = retry_cnt + CNT_W'(1);
                    snap_nxt  = Q_fb;
                    cnt_nxt   = '0;
                    state_nxt = DRIVE;
                    s_nxt     = set_mask(tgt, Q_fb);
                    r_nxt     = clr_mask(tgt, Q_fb);
                end else
`endif
                begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                    err_nxt   = |mism;
                    ready_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                ready_nxt = 1'b1;
            end
        endcase
    end

    // State and registered outputs; async reset drops S/R immediately.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            tgt       <= '0;
            snap      <= '0;
            cnt       <= '0;
            S         <= '0;
            R         <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            err_bits  <= '0;
            req_ready <= 1'b1;
`ifdef SR_DRV_RETRY_EN
            retry_cnt <= '0;
`endif
        end else begin
            state     <= state_nxt;
            tgt       <= tgt_nxt;
            snap      <= snap_nxt;
            cnt       <= cnt_nxt;
            S         <= s_nxt;
            R         <= r_nxt;
            done      <= done_nxt;
            err       <= err_nxt;
            err_bits  <= err_bits_nxt;
            req_ready <= ready_nxt;
`ifdef SR_DRV_RETRY_EN
            retry_cnt <= retry_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_sr_flipflop_driver.sv
// Testbench for sr_flipflop_driver: an SR flop bank model closes the loop.
// A timeline model predicts S/R/req_ready each cycle. It also queues the
// expected done/err/err_bits at each final check, to be popped on the done cycle.
module tb_sr_flipflop_driver;
    localparam int W  = 8;
    localparam int P  = 1;
    localparam int ST = 2;
    localparam int MR = 2;
`ifdef SR_DRV_RETRY_EN
    localparam int RETRY_LIMIT = MR;
`else
    localparam int RETRY_LIMIT = 0;
`endif
    localparam int LAT1      = P + ST + 2;
    localparam int LAT_STUCK = LAT1 + RETRY_LIMIT * (P + ST + 1);

    logic         CLK, RST, req_valid, req_ready, done, err;
    logic [W-1:0] req_data, Q_fb, S, R, err_bits;

    int n_tests = 0;
    int n_fail  = 0;

    sr_flipflop_driver #(
        .WIDTH(W), .PULSE_CYCLES(P), .SETTLE_CYCLES(ST), .MAX_RETRY(MR)
    ) dut (
        .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .Q_fb(Q_fb), .S(S), .R(R), .done(done),
        .err(err), .err_bits(err_bits)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", tag, got, exp);
        end
    endtask

    // SR flop bank model with a preload port, a stuck-at-0 mask and a random mode.
    logic [W-1:0] q, ld_val, stuck0, q_rand;
    logic         ld, rand_mode;

    always @(posedge CLK) begin
        if (ld) q <= ld_val;
        else    q <= (q & ~R) | S;
    end

    assign Q_fb = rand_mode ? q_rand : (q & ~stuck0);

    // Timeline model and scoreboard, evaluated mid-cycle.
    typedef struct {
        int           cyc;
        logic         err;
        logic [W-1:0] bits;
    } exp_t;

    exp_t         sbq[$];
    int           mcyc = 0;
    bit           busy = 1'b0;
    int           t = 0;
    int           retries = 0;
    logic [W-1:0] m_tgt, m_snap;

    always @(negedge CLK) begin
        logic [W-1:0] es, er, mm;
        logic         eready, edone;
        exp_t         e;
        mcyc++;
        if (RST) begin
            busy = 1'b0;
            sbq.delete();
        end else begin
            es     = '0;
            er     = '0;
            eready = !busy;
            if (busy) begin
                t++;
                if (t >= 1 && t <= P) begin
                    es = m_tgt & ~m_snap;
                    er = ~m_tgt & m_snap;
                end
                if (t == P + ST + 1) begin
                    mm = Q_fb ^ m_tgt;
                    if (mm != '0 && retries < RETRY_LIMIT) begin
                        retries++;
                        m_snap = Q_fb;
                        t      = 0;
                    end else begin
                        e.cyc  = mcyc + 1;
                        e.err  = |mm;
                        e.bits = mm;
                        sbq.push_back(e);
                        busy = 1'b0;
                    end
                end
            end else if (req_valid) begin
                busy    = 1'b1;
                t       = 0;
                m_tgt   = req_data;
                m_snap  = Q_fb;
                retries = 0;
            end
            chk("S", 32'(S), 32'(es));
            chk("R", 32'(R), 32'(er));
            chk("S_and_R", 32'(S & R), 32'd0);
            chk("req_ready", 32'(req_ready), 32'(eready));
            edone = (sbq.size() > 0) && (sbq[0].cyc == mcyc);
            chk("done", 32'(done), 32'(edone));
            if (edone) begin
                e = sbq.pop_front();
                chk("sb_err", 32'(err), 32'(e.err));
                chk("sb_err_bits", 32'(err_bits), 32'(e.bits));
            end
        end
    end

    task automatic preload(input logic [W-1:0] v);
        @(posedge CLK);
        #1 ld = 1'b1; ld_val = v;
        @(posedge CLK);
        #1 ld = 1'b0;
    endtask

    task automatic run_req(input string tag, input logic [W-1:0] d, input logic ee,
                           input logic [W-1:0] eb, input int elat);
        int n;
        bit seen;
        @(posedge CLK);
        #1 req_valid = 1'b1; req_data = d;
        @(posedge CLK);
        #1 req_valid = 1'b0; req_data = W'($urandom);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 60) begin
            @(negedge CLK);
            n++;
            if (done) seen = 1'b1;
        end
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        chk({tag, "_latency"}, n, elat);
        chk({tag, "_err"}, 32'(err), 32'(ee));
        chk({tag, "_err_bits"}, 32'(err_bits), 32'(eb));
    endtask

    initial begin
        int nd;
        RST = 1'b1; req_valid = 1'b0; req_data = '0;
        ld = 1'b1; ld_val = '0; stuck0 = '0; q_rand = '0; rand_mode = 1'b0;
        repeat (3) @(posedge CLK);
        #1 ld = 1'b0;
        chk("rst_S", 32'(S), 32'd0);
        chk("rst_R", 32'(R), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_err_bits", 32'(err_bits), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd1);
        #1 RST = 1'b0;

        // Reset in the middle of DRIVE.
        preload(8'h00);
        @(posedge CLK);
        #1 req_valid = 1'b1; req_data = 8'hFF;
        @(posedge CLK);
        #1 req_valid = 1'b0;
        chk("t1_S_drive", 32'(S), 32'hFF);
        chk("t1_R_drive", 32'(R), 32'h00);
        #1 RST = 1'b1;
        #1;
        chk("t1_S_async", 32'(S), 32'h00);
        chk("t1_R_async", 32'(R), 32'h00);
        chk("t1_done_async", 32'(done), 32'd0);
        repeat (2) @(posedge CLK);
        #2 RST = 1'b0;
        nd = 0;
        repeat (8) begin
            @(negedge CLK);
            if (done) nd++;
        end
        chk("t1_no_done", nd, 0);
        chk("t1_ready_after", 32'(req_ready), 32'd1);

        // Normal requests with a healthy bank.
        preload(8'h0F);
        run_req("t2", 8'hF0, 1'b0, 8'h00, LAT1);
        preload(8'h55);
        run_req("t2b", 8'hAA, 1'b0, 8'h00, LAT1);
        preload(8'hFF);
        run_req("t2c", 8'h00, 1'b0, 8'h00, LAT1);

        // Target already matches.
        preload(8'h3C);
        run_req("t3", 8'h3C, 1'b0, 8'h00, LAT1);

        // Bit 2 stuck at 0.
        preload(8'h00);
        stuck0 = 8'h04;
        run_req("t4", 8'h04, 1'b1, 8'h04, LAT_STUCK);
        stuck0 = 8'h00;
        preload(8'h00);

        // req_valid held high with fresh data every cycle.
        @(posedge CLK);
        #1 req_valid = 1'b1; req_data = W'($urandom);
        nd = 0;
        for (int i = 0; i < 26; i++) begin
            @(negedge CLK);
            if (done) nd++;
            @(posedge CLK);
            #1 req_data = W'($urandom);
        end
        req_valid = 1'b0;
        chk("t5_b2b_done_count", nd, 5);
        repeat (20) @(posedge CLK);

        // Random requests and random feedback.
        #1 rand_mode = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            @(posedge CLK);
            #1 req_valid = 1'($urandom_range(0, 1));
            req_data = W'($urandom);
            q_rand   = W'($urandom);
        end
        req_valid = 1'b0;
        repeat (40) @(posedge CLK);
        chk("sb_drained", sbq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
